// File: rtl/sprite_addr_calc.sv
// sprite_addr_calc: per-pixel sprite footprint test and sprite-memory address
// generator. One registered stage: outputs reflect the inputs sampled at the
// previous rising edge.
module sprite_addr_calc (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] pattern_info,
  input  logic [31:0] sprite_info,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] addr_output,
  output logic        valid
);

  // Pattern descriptor fields
  logic [15:0] append;
  logic [15:0] res_h;
  logic [15:0] res_v;
  logic [15:0] act_h;
  logic [15:0] act_v;

  // Sprite state fields (attributes [9:0] are not used here)
  logic        visible;
  logic        hflip;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;

  assign append  = pattern_info[79:64];
  assign res_h   = pattern_info[63:48];
  assign res_v   = pattern_info[47:32];
  assign act_h   = pattern_info[31:16];
  assign act_v   = pattern_info[15:0];

  assign visible = sprite_info[31];
  assign hflip   = sprite_info[30];
  assign pos_x   = sprite_info[29:20];
  assign pos_y   = sprite_info[19:10];

  // Intermediate combinational values, all 17 bits so the footprint end
  // (position + active size) never wraps.
  logic [16:0] dx;
  logic [16:0] dy;
  logic [16:0] h_end;
  logic [16:0] v_end;
  logic        h_hit;
  logic        v_hit;
  logic [16:0] col;
  logic [16:0] row;
  logic        stored;
  logic [31:0] row_base;
  logic [15:0] addr_sum;

  logic        valid_d;
  logic        valid_q;
  logic [15:0] addr_d;
  logic [15:0] addr_q;

  // Footprint test, flip mapping, storage clip and linear address
  always_comb begin
    dx       = {7'd0, hcount} - {7'd0, pos_x};
    dy       = {7'd0, vcount} - {7'd0, pos_y};
    h_end    = {7'd0, pos_x} + {1'b0, act_h};
    v_end    = {7'd0, pos_y} + {1'b0, act_v};
    h_hit    = ({7'd0, hcount} >= {7'd0, pos_x}) && ({7'd0, hcount} < h_end);
    v_hit    = ({7'd0, vcount} >= {7'd0, pos_y}) && ({7'd0, vcount} < v_end);

    // Mirrored column only matters inside the footprint, where dx < act_h,
    // so the subtraction cannot underflow there.
    if (hflip) begin
      col = {1'b0, act_h} - 17'd1 - dx;
    end else begin
      col = dx;
    end
    row      = dy;

    // Footprint pixels beyond the stored image are transparent.
    stored   = (col < {1'b0, res_h}) && (row < {1'b0, res_v});

    // Inside the footprint row fits in 16 bits; full product, then truncate.
    row_base = row[15:0] * res_h;
    addr_sum = append + row_base[15:0] + col[15:0];

    valid_d  = visible && h_hit && v_hit && stored;
    addr_d   = valid_d ? addr_sum : 16'd0;
  end

  // Output register; synchronous reset overrides any hit this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= 16'd0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid       = valid_q;
  assign addr_output = addr_q;

endmodule

// File: tb/tb_sprite_addr_calc.sv
// tb_sprite_addr_calc: directed vectors with hand-computed expectations.
// The driver pushes {valid, addr} per applied vector; an independent monitor
// pops and compares one cycle later.
module tb_sprite_addr_calc;

  logic        clk;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  logic [16:0] exp_q[$];
  logic        drv_flag;
  int          n_checks;
  int          n_errors;

  sprite_addr_calc dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] pat(input logic [15:0] app, input logic [15:0] rh,
                                      input logic [15:0] rv, input logic [15:0] ah,
                                      input logic [15:0] av);
    return {app, rh, rv, ah, av};
  endfunction

  function automatic logic [31:0] spr(input logic vis, input logic flip,
                                      input logic [9:0] x, input logic [9:0] y);
    return {vis, flip, x, y, 10'h2a5};
  endfunction

  // Driver: apply one vector at the falling edge and queue its expectation
  task automatic drive(input logic rst, input logic [79:0] p, input logic [31:0] s,
                       input logic [9:0] h, input logic [9:0] v,
                       input logic ev, input logic [15:0] ea);
    @(negedge clk);
    reset        = rst;
    pattern_info = p;
    sprite_info  = s;
    hcount       = h;
    vcount       = v;
    drv_flag     = 1'b1;
    exp_q.push_back({ev, ea});
  endtask

  task automatic idle();
    @(negedge clk);
    drv_flag = 1'b0;
  endtask

  // Monitor: after each rising edge that captured a driven vector, compare
  always @(posedge clk) begin
    logic        take;
    logic [16:0] exp;
    take = drv_flag;
    #1;
    if (take) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_underflow: got valid=%0b addr=%0d, required an expectation",
                 valid, addr_output);
      end else begin
        exp = exp_q.pop_front();
        if ({valid, addr_output} !== exp) begin
          n_errors++;
          $display("FAIL pixel #%0d: got valid=%0b addr=%0d, required valid=%0b addr=%0d",
                   n_checks, valid, addr_output, exp[16], exp[15:0]);
        end
      end
    end
  end

  logic [79:0] p_basic, p_app, p_clip, p_wrap, p_zero_act, p_zero_res;
  logic [31:0] s_basic, s_flip, s_orig, s_hide, s_edge;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    drv_flag     = 1'b0;
    reset        = 1'b1;
    pattern_info = '0;
    sprite_info  = '0;
    hcount       = '0;
    vcount       = '0;

    p_basic    = pat(16'd0,      16'd14, 16'd15, 16'd14, 16'd15);
    p_app      = pat(16'd512,    16'd32, 16'd32, 16'd32, 16'd32);
    p_clip     = pat(16'd0,      16'd14, 16'd15, 16'd20, 16'd20);
    p_wrap     = pat(16'hfff0,   16'd32, 16'd32, 16'd32, 16'd32);
    p_zero_act = pat(16'd0,      16'd14, 16'd15, 16'd0,  16'd15);
    p_zero_res = pat(16'd0,      16'd0,  16'd15, 16'd14, 16'd15);
    s_basic    = spr(1'b1, 1'b0, 10'd100, 10'd50);
    s_flip     = spr(1'b1, 1'b1, 10'd100, 10'd50);
    s_orig     = spr(1'b1, 1'b0, 10'd0,   10'd0);
    s_hide     = spr(1'b0, 1'b0, 10'd100, 10'd50);
    s_edge     = spr(1'b1, 1'b0, 10'd1020, 10'd0);

    repeat (2) @(negedge clk);

    // Reset held with a covering sprite, then release
    drive(1'b1, p_basic, s_basic, 10'd105, 10'd55, 1'b0, 16'd0);
    drive(1'b1, p_basic, s_basic, 10'd105, 10'd55, 1'b0, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd105, 10'd55, 1'b1, 16'd75);

    // Basic hit and footprint edges
    drive(1'b0, p_basic, s_basic, 10'd100, 10'd50, 1'b1, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd113, 10'd64, 1'b1, 16'd209);
    drive(1'b0, p_basic, s_basic, 10'd114, 10'd50, 1'b0, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd100, 10'd65, 1'b0, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd99,  10'd50, 1'b0, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd100, 10'd49, 1'b0, 16'd0);

    // Append offset and 16-bit wrap of the address
    drive(1'b0, p_app,  s_orig, 10'd5, 10'd2, 1'b1, 16'd581);
    drive(1'b0, p_wrap, s_orig, 10'd5, 10'd2, 1'b1, 16'd53);

    // Horizontal flip
    drive(1'b0, p_basic, s_flip, 10'd100, 10'd50, 1'b1, 16'd13);
    drive(1'b0, p_basic, s_flip, 10'd113, 10'd51, 1'b1, 16'd14);

    // Invisible sprite and storage clip (plain and mirrored)
    drive(1'b0, p_basic, s_hide, 10'd105, 10'd55, 1'b0, 16'd0);
    drive(1'b0, p_clip,  s_basic, 10'd115, 10'd50, 1'b0, 16'd0);
    drive(1'b0, p_clip,  s_basic, 10'd105, 10'd50, 1'b1, 16'd5);
    drive(1'b0, p_clip,  s_flip,  10'd100, 10'd50, 1'b0, 16'd0);
    drive(1'b0, p_clip,  s_flip,  10'd119, 10'd50, 1'b1, 16'd0);

    // Zero active size and zero stored size
    drive(1'b0, p_zero_act, s_basic, 10'd100, 10'd50, 1'b0, 16'd0);
    drive(1'b0, p_zero_res, s_basic, 10'd100, 10'd50, 1'b0, 16'd0);

    // Footprint extending past column 1023 (sum must not wrap)
    drive(1'b0, p_basic, s_edge, 10'd1023, 10'd0, 1'b1, 16'd3);
    drive(1'b0, p_basic, s_edge, 10'd2,    10'd0, 1'b0, 16'd0);

    // Latency: consecutive cycles stepping hcount
    drive(1'b0, p_basic, s_basic, 10'd99,  10'd50, 1'b0, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd100, 10'd50, 1'b1, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd101, 10'd50, 1'b1, 16'd1);

    // Mid-frame reset overrides a hit, then normal operation resumes
    drive(1'b1, p_basic, s_basic, 10'd101, 10'd50, 1'b0, 16'd0);
    drive(1'b0, p_basic, s_basic, 10'd102, 10'd51, 1'b1, 16'd16);

    idle();
    repeat (3) @(negedge clk);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required finish before 100000");
    $fatal(1);
  end

endmodule
